// File: rtl/bitreversal_sched.sv
// Round-robin scheduler sharing one bit-reversal core among NUM_REQ requesters.
// Latency: grant T, write T+1, start T+2, first wait T+3; minimum grant-to-response is 5 cycles.
// Backpressure: the response is held in RESP until the owner raises rsp_ready_i; no new grant until then.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_i / req_data_i        per-requester job request (held until granted) and 32-bit input word
//   gnt_o                     one-hot single-cycle grant (combinational in IDLE)
//   rsp_valid_o/rsp_ready_i   one-hot response handshake towards the job owner
//   rsp_data_o / rsp_err_o    shared result word and timeout flag (data forced to 0 on timeout)
//   busy_o                    a job is in flight
//   core_*                    write / start / read strobes, data and done towards the core
module bitreversal_sched #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [31:0]           core_din_o,
  output logic                  core_write_o,
  output logic                  core_start_o,
  output logic                  core_read_o,
  input  logic [31:0]           core_dout_i,
  input  logic                  core_done_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4,
    RESP  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  int            scan_idx;

  // Round-robin pick: first asserted request at or after the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!pick_vld && req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(scan_idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          data_d  = req_data_i[32*int'(pick_idx) +: 32];
          err_d   = 1'b0;
          ptr_d   = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : PW'(pick_idx + 1'b1);
          state_d = WRITE;
        end
      end
      WRITE: state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done is tested before the limit, so done on the last allowed cycle still succeeds.
        if (core_done_i) begin
          state_d = READ;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        data_d  = core_dout_i;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_o        = '0;
    rsp_valid_o  = '0;
    rsp_data_o   = '0;
    rsp_err_o    = 1'b0;
    busy_o       = (state_q != IDLE);
    core_din_o   = (state_q != IDLE) ? data_q : 32'd0;
    core_write_o = (state_q == WRITE);
    core_start_o = (state_q == START);
    core_read_o  = (state_q == READ);
    // Grant is combinational; gate with reset so every output is 0 while reset is held.
    if (state_q == IDLE && pick_vld && rst_ni) gnt_o[pick_idx] = 1'b1;
    if (state_q == RESP) begin
      rsp_valid_o[owner_q] = 1'b1;
      rsp_data_o           = data_q;
      rsp_err_o            = err_q;
    end
  end

endmodule

// File: tb/tb_bitreversal_sched.sv
// Directed bench for bitreversal_sched with a behavioural bit-reversal core model.
// Latency: n/a (bench).
// Backpressure: bench drives rsp_ready_i per scenario.
module tb_bitreversal_sched;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [NUM_REQ-1:0]    req_i = '0;
  logic [NUM_REQ*32-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [NUM_REQ-1:0]    rsp_ready_i = '0;
  logic [31:0]           rsp_data_o;
  logic                  rsp_err_o;
  logic                  busy_o;
  logic [31:0]           core_din_o;
  logic                  core_write_o;
  logic                  core_start_o;
  logic                  core_read_o;
  logic [31:0]           core_dout_i;
  logic                  core_done_i;

  int total = 0;
  int bad   = 0;

  bitreversal_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_data_i(req_data_i),
    .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .core_din_o(core_din_o), .core_write_o(core_write_o), .core_start_o(core_start_o),
    .core_read_o(core_read_o), .core_dout_i(core_dout_i), .core_done_i(core_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Core model: latches the written word, raises done 'delay' cycles after start, holds until read.
  logic [31:0] core_lat = '0;
  logic        armed = 1'b0;
  int          dcnt = 0;
  int          delay = 1;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (core_write_o) core_lat <= core_din_o;
    if (core_start_o) begin
      armed <= 1'b1;
      dcnt  <= 0;
    end else if (core_read_o) begin
      armed <= 1'b0;
    end else if (armed && dcnt < 100000) begin
      dcnt <= dcnt + 1;
    end
  end

  assign core_done_i = armed && (dcnt >= delay - 1);
  assign core_dout_i = rev32(core_lat);

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i = 2'b11;
    rsp_ready_i = '0;
    @(negedge clk_i);
    #1;
    total++;
    if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
    total++;
    if ({busy_o, rsp_valid_o, rsp_err_o, core_write_o, core_start_o, core_read_o} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000",
                      {busy_o, rsp_valid_o, rsp_err_o, core_write_o, core_start_o, core_read_o});
    end
    total++;
    if ({rsp_data_o, core_din_o} !== 64'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", rsp_data_o, core_din_o);
    end
    @(negedge clk_i);
    req_i = '0;
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] exp;
    @(negedge clk_i);
    delay = 3;
    req_data_i[31:0] = 32'h0000_0001;
    req_i = 2'b01;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b exp=01", gnt_o); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_i);
      if (k == 1) req_i = '0;
      #1;
      exp = {k == 1, k == 2, k == 6, (k == 7) ? 2'b01 : 2'b00};
      total++;
      if ({core_write_o, core_start_o, core_read_o, rsp_valid_o} !== exp) begin
        bad++; $display("FAIL single_seq cycle=%0d got=%b exp=%b", k,
                        {core_write_o, core_start_o, core_read_o, rsp_valid_o}, exp);
      end
      if (k == 1) begin
        total++;
        if (core_din_o !== 32'h0000_0001) begin
          bad++; $display("FAIL single_din got=%h exp=00000001", core_din_o);
        end
      end
    end
    total++;
    if ({rsp_data_o, rsp_err_o, busy_o} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL single_rsp got=%h err=%b busy=%b exp=80000000 err=0 busy=1",
                      rsp_data_o, rsp_err_o, busy_o);
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    rsp_ready_i = '0;
    #1;
    total++;
    if ({busy_o, rsp_valid_o} !== 3'b000) begin
      bad++; $display("FAIL single_done got=%b exp=000", {busy_o, rsp_valid_o});
    end
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] exp_g;
    logic [31:0] exp_d;
    delay = 1;
    req_data_i = {32'h0000_000F, 32'h0000_0001};
    req_i = 2'b11;
    rsp_ready_i = '0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (j % 2 == 0) ? 32'h8000_0000 : 32'hF000_0000;
      n = 0;
      while (gnt_o == '0 && n < 20) begin @(negedge clk_i); #1; n++; end
      total++;
      if (gnt_o !== exp_g) begin bad++; $display("FAIL contend_gnt job=%0d got=%b exp=%b", j, gnt_o, exp_g); end
      n = 0;
      while (rsp_valid_o == '0 && n < 20) begin @(negedge clk_i); #1; n++; end
      total++;
      if ({rsp_valid_o, rsp_data_o} !== {exp_g, exp_d}) begin
        bad++; $display("FAIL contend_rsp job=%0d got=%b/%h exp=%b/%h", j, rsp_valid_o, rsp_data_o, exp_g, exp_d);
      end
      rsp_ready_i = 2'b11;
      @(negedge clk_i);
      rsp_ready_i = '0;
      if (j == 3) req_i = '0;
      #1;
    end
  endtask

  task automatic test_backpressure();
    int n;
    delay = 2;
    req_data_i = {32'h0000_0100, 32'h0000_0002};
    @(negedge clk_i);
    req_i = 2'b11;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL bp_gnt0 got=%b exp=01", gnt_o); end
    n = 0;
    while (rsp_valid_o == '0 && n < 20) begin @(negedge clk_i); #1; n++; end
    total++;
    if ({rsp_valid_o, rsp_data_o} !== {2'b01, 32'h4000_0000}) begin
      bad++; $display("FAIL bp_rsp0 got=%b/%h exp=01/40000000", rsp_valid_o, rsp_data_o);
    end
    for (int k = 0; k < 10; k++) begin
      rsp_ready_i = 2'b10;
      @(negedge clk_i);
      #1;
      total++;
      if ({rsp_valid_o, gnt_o, rsp_err_o, rsp_data_o} !== {2'b01, 2'b00, 1'b0, 32'h4000_0000}) begin
        bad++; $display("FAIL bp_hold cycle=%0d got=%b/%b/%b/%h exp=01/00/0/40000000",
                        k, rsp_valid_o, gnt_o, rsp_err_o, rsp_data_o);
      end
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    rsp_ready_i = '0;
    #1;
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL bp_gnt1 got=%b exp=10", gnt_o); end
    @(negedge clk_i);
    req_i = '0;
    n = 0;
    while (rsp_valid_o == '0 && n < 20) begin @(negedge clk_i); #1; n++; end
    total++;
    if ({rsp_valid_o, rsp_data_o} !== {2'b10, 32'h0080_0000}) begin
      bad++; $display("FAIL bp_rsp1 got=%b/%h exp=10/00800000", rsp_valid_o, rsp_data_o);
    end
    rsp_ready_i = 2'b10;
    @(negedge clk_i);
    rsp_ready_i = '0;
  endtask

  task automatic test_timeout();
    logic [2:0] exp;
    delay = 1000;
    req_data_i[31:0] = 32'h1234_5678;
    @(negedge clk_i);
    req_i = 2'b01;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL to_gnt got=%b exp=01", gnt_o); end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_i);
      if (k == 1) req_i = '0;
      #1;
      exp = {1'b0, (k == 11) ? 2'b01 : 2'b00};
      total++;
      if ({core_read_o, rsp_valid_o} !== exp) begin
        bad++; $display("FAIL to_seq cycle=%0d got=%b exp=%b", k, {core_read_o, rsp_valid_o}, exp);
      end
    end
    total++;
    if ({rsp_err_o, rsp_data_o} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL to_rsp got=err %b data %h exp=err 1 data 00000000", rsp_err_o, rsp_data_o);
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    rsp_ready_i = '0;
  endtask

  task automatic test_last_cycle();
    logic [2:0] exp;
    delay = 8;
    req_data_i[63:32] = 32'h0000_0003;
    @(negedge clk_i);
    req_i = 2'b10;
    #1;
    total++;
    if (gnt_o !== 2'b10) begin bad++; $display("FAIL last_gnt got=%b exp=10", gnt_o); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      if (k == 1) req_i = '0;
      #1;
      exp = {k == 11, (k == 12) ? 2'b10 : 2'b00};
      total++;
      if ({core_read_o, rsp_valid_o} !== exp) begin
        bad++; $display("FAIL last_seq cycle=%0d got=%b exp=%b", k, {core_read_o, rsp_valid_o}, exp);
      end
    end
    total++;
    if ({rsp_err_o, rsp_data_o} !== {1'b0, 32'hC000_0000}) begin
      bad++; $display("FAIL last_rsp got=err %b data %h exp=err 0 data c0000000", rsp_err_o, rsp_data_o);
    end
    rsp_ready_i = 2'b10;
    @(negedge clk_i);
    rsp_ready_i = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    delay = 1000;
    req_data_i = {32'h0000_000F, 32'h0000_0001};
    @(negedge clk_i);
    req_i = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      req_i = '0;
    end
    rst_ni = 1'b0;
    req_i = 2'b11;
    #1;
    total++;
    if ({busy_o, rsp_valid_o, gnt_o, core_write_o, core_start_o, core_read_o, rsp_err_o} !== 9'd0) begin
      bad++; $display("FAIL mid_reset_ctrl got=%b exp=000000000",
                      {busy_o, rsp_valid_o, gnt_o, core_write_o, core_start_o, core_read_o, rsp_err_o});
    end
    total++;
    if ({core_din_o, rsp_data_o} !== 64'd0) begin
      bad++; $display("FAIL mid_reset_data got=%h/%h exp=0/0", core_din_o, rsp_data_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if (gnt_o !== 2'b01) begin bad++; $display("FAIL mid_first_gnt got=%b exp=01", gnt_o); end
    @(negedge clk_i);
    req_i = '0;
    delay = 1;
    n = 0;
    while (rsp_valid_o == '0 && n < 20) begin @(negedge clk_i); #1; n++; end
    total++;
    if ({rsp_valid_o, rsp_err_o, rsp_data_o} !== {2'b01, 1'b0, 32'h8000_0000}) begin
      bad++; $display("FAIL mid_rsp got=%b/%b/%h exp=01/0/80000000", rsp_valid_o, rsp_err_o, rsp_data_o);
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    rsp_ready_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_last_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bitreversal_sched.md
Name: bitreversal_sched

Overview:
- Round-robin scheduler that shares one bit-reversal core among NUM_REQ requesters (e.g. the CPU register path and a DMA channel).
- Accepts one 32-bit job at a time and sequences the core through its write / start / wait-done / read protocol.
- Returns the result, with an error flag on timeout, to the requester that issued the job.
- Sits between the requester ports and the bit-reversal core, replacing direct register-driven control of the core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 1024, maximum cycles to wait for core_done_i before aborting the job (must be ≥ 2).
- TW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester job request, held until granted.
- req_data_i  in  NUM_REQ*32  per-requester input word; slice k = [32k+31:32k].
- gnt_o  out  NUM_REQ  one-hot, 1-cycle grant; job accepted.
- rsp_valid_o  out  NUM_REQ  one-hot; result pending for that requester.
- rsp_ready_i  in  NUM_REQ  requester accepts the result.
- rsp_data_o  out  32  result word, shared by all requesters.
- rsp_err_o  out  1  job timed out; rsp_data_o = 0.
- busy_o  out  1  a job is in flight (state != IDLE).
- core_din_o  out  32  data to core.
- core_write_o  out  1  1-cycle load of core_din_o into core.
- core_start_o  out  1  1-cycle start pulse.
- core_read_o  out  1  1-cycle result read/acknowledge.
- core_dout_i  in  32  core result.
- core_done_i  in  1  core result ready (level, held until read).

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 has highest priority first), captured data/owner/counter cleared.
- Reset mid-job aborts the job silently; no response is issued afterwards.
- FSM states: IDLE, WRITE, START, WAIT, READ, RESP.
- IDLE:
  - If any req_i is set, grant the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - gnt_o[k] = 1 combinationally in that cycle.
  - Capture req_data_i slice k and owner = k.
  - Pointer <= k+1 mod NUM_REQ.
  - Next state: WRITE.
  - If no request, remain in IDLE.
- WRITE: core_write_o = 1, core_din_o = captured data → START.
- START: core_start_o = 1; clear timeout counter → WAIT.
- WAIT:
  - If core_done_i = 1 → READ.
  - Else increment counter. When counter reaches TIMEOUT-1, set err, clear data → RESP.
  - Result: done seen within the first TIMEOUT WAIT cycles succeeds; otherwise the job errors.
- READ: core_read_o = 1; capture core_dout_i into data; err = 0 → RESP.
- RESP:
  - rsp_valid_o[owner] = 1; rsp_data_o and rsp_err_o stable.
  - Hold until rsp_ready_i[owner] = 1, then → IDLE.
  - rsp_ready_i bits of other requesters are ignored.
- core_din_o holds the captured data from WRITE onward; it is 0 in IDLE.
- All core_* strobes are single-cycle and mutually exclusive.
- Latency: grant cycle T; write T+1; start T+2; first WAIT T+3. If done is already high at T+3: read T+4, rsp_valid_o asserted T+5. Minimum grant-to-response is 5 cycles.
- Throughput: next grant can occur no earlier than the cycle after the response handshake (IDLE cycle).
- Simultaneous requests are resolved by round-robin, never starvation: each requester waits at most NUM_REQ-1 jobs.
- A requester dropping req_i before grant simply loses its turn. No grant is given to an unasserted req_i.
- core_done_i asserted outside WAIT is ignored.
- A late done arriving after a timeout is consumed by the next job's WAIT. The core's owner guarantees a core reset in that case; the scheduler does not filter it.
- busy_o = 1 in every state except IDLE.

Test Plan:
- Single job: req_i=01, req_data_i[31:0]=0x00000001; core model raises done 3 cycles after start with dout=0x80000000 → gnt_o=01 at T, strobes write/start/read at T+1/T+2/T+6, rsp_valid_o=01, rsp_data_o=0x80000000, rsp_err_o=0.
- Contention: req_i=11 held continuously after reset → grants alternate 01,10,01,10. Responses route to the matching rsp_valid_o bit with the corresponding data.
- Backpressure: rsp_ready_i=0 for 10 cycles during RESP → rsp_valid_o and rsp_data_o held stable, no new gnt_o despite pending req_i. rsp_ready_i on the non-owner bit has no effect.
- Timeout: TIMEOUT=8, core never asserts done → after 8 WAIT cycles, rsp_valid_o set with rsp_err_o=1, rsp_data_o=0, core_read_o never pulsed.
- Done on last allowed cycle: TIMEOUT=8, done rises on the 8th WAIT cycle → success, err=0, data=core_dout_i.
- Reset mid-WAIT: assert rst_ni=0 for 2 cycles → all outputs 0 immediately. After release, first grant goes to requester 0 when req_i=11.
